// File: rtl/pwm_lbus.sv
// pwm_lbus - multi-channel PWM generator, slave on the XT_LB low-speed bus.
//
// Period and duty values are written to shadow registers and copied into the
// active registers only at a period boundary (or continuously while disabled).
// This keeps the outputs glitch-free.
//
// Optional feature macro: PWM_LBUS_IRQ_EN
//   Adds STATUS.bit1 irq_en and the level interrupt output irq.
//
// Ports:
//   clk       in   peripheral clock, rising-edge logic
//   rstn      in   asynchronous active-low reset
//   lb_sel    in   slave selected this cycle
//   lb_we     in   1 = write, 0 = read
//   lb_addr   in   [7:0] word address
//   lb_wdata  in   [31:0] write data
//   rdata     out  [31:0] combinational read data (0 if unselected/unmapped)
//   pwm_out   out  [CH_NUM-1:0] registered PWM outputs
//   irq       out  period-done interrupt (only with PWM_LBUS_IRQ_EN)
//
// Register map (word offsets from BASE_ADDR):
//   +0            CTRL    bit0 en, bits[8+CH_NUM-1:8] oe, bits[23:16] psc
//   +1            PERIOD  period shadow
//   +2..+1+CH_NUM DUTY[i] duty shadow of channel i
//   +2+CH_NUM     STATUS  bit0 done (W1C), bit1 irq_en
//
// Bus protocol: single-cycle accesses with no wait states and no handshake.
// A write commits on the rising edge where lb_sel & lb_we is high. A read
// returns rdata combinationally in the same cycle lb_sel is high.
module pwm_lbus #(
  parameter int          CH_NUM    = 4,
  parameter int          CNT_WIDTH = 16,
  parameter logic [7:0]  BASE_ADDR = 8'd40
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                lb_sel,
  input  logic                lb_we,
  input  logic [7:0]          lb_addr,
  input  logic [31:0]         lb_wdata,
  output logic [31:0]         rdata,
  output logic [CH_NUM-1:0]   pwm_out
`ifdef PWM_LBUS_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam logic [7:0] OFF_CTRL   = 8'd0;
  localparam logic [7:0] OFF_PERIOD = 8'd1;
  localparam logic [7:0] OFF_STATUS = 8'(2 + CH_NUM);

  // Address decode. The 9-bit difference flags addresses below BASE_ADDR.
  logic [8:0] off_full;
  logic [7:0] off;
  logic       hit;
  logic       wr;
  logic       wr_ctrl;
  logic       wr_period;
  logic       wr_status;

  assign off_full  = {1'b0, lb_addr} - {1'b0, BASE_ADDR};
  assign off       = off_full[7:0];
  assign hit       = !off_full[8] && (off <= OFF_STATUS);
  assign wr        = lb_sel & lb_we & hit;
  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_period = wr && (off == OFF_PERIOD);
  assign wr_status = wr && (off == OFF_STATUS);

  // Programmer-visible registers
  logic                 en;
  logic [CH_NUM-1:0]    oe;
  logic [7:0]           psc;
  logic [CNT_WIDTH-1:0] period_sh;
  logic [CNT_WIDTH-1:0] duty_sh [CH_NUM];
  logic                 done;

  // Active registers and counters
  logic [CNT_WIDTH-1:0] period_act;
  logic [CNT_WIDTH-1:0] duty_act [CH_NUM];
  logic [7:0]           pcnt;
  logic [CNT_WIDTH-1:0] cnt;

  logic run;
  logic tick;
  logic wrap;

  // Counting continues on this edge only if enabled and not being disabled
  // by a CTRL write on the same edge (a disable clears the counters at once).
  assign run  = en & ~(wr_ctrl & ~lb_wdata[0]);
  assign tick = (pcnt == psc);
  assign wrap = run & tick & (cnt == period_act);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en        <= 1'b0;
      oe        <= '0;
      psc       <= '0;
      period_sh <= '0;
    end else begin
      if (wr_ctrl) begin
        en  <= lb_wdata[0];
        oe  <= lb_wdata[8 +: CH_NUM];
        psc <= lb_wdata[23:16];
      end
      if (wr_period) begin
        period_sh <= lb_wdata[CNT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH_NUM; i++) begin
        duty_sh[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (wr && (off == 8'(2 + i))) begin
          duty_sh[i] <= lb_wdata[CNT_WIDTH-1:0];
        end
      end
    end
  end

  // Prescaler and period counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (!run) begin
      pcnt <= '0;
      cnt  <= '0;
    end else begin
      pcnt <= tick ? 8'd0 : pcnt + 8'd1;
      if (tick) begin
        cnt <= (cnt == period_act) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Shadow-to-active transfer: at every wrap, and continuously while disabled
  // so that an enable always starts from the latest programmed values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_act <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        duty_act[i] <= '0;
      end
    end else if (!en || wrap) begin
      period_act <= period_sh;
      for (int i = 0; i < CH_NUM; i++) begin
        duty_act[i] <= duty_sh[i];
      end
    end
  end

  // Outputs compare the pre-update counter value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        pwm_out[i] <= en & oe[i] & (cnt < duty_act[i]);
      end
    end
  end

  // done: set on every wrap; a simultaneous W1C loses to the set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done <= 1'b0;
    end else if (wrap) begin
      done <= 1'b1;
    end else if (wr_status && lb_wdata[0]) begin
      done <= 1'b0;
    end
  end

`ifdef PWM_LBUS_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_status) begin
        irq_en <= lb_wdata[1];
      end
      irq <= done & irq_en;
    end
  end
`endif

  // Read mux: returns shadow values; unused bits are 0.
  always_comb begin
    rdata = '0;
    if (lb_sel && hit) begin
      if (off == OFF_CTRL) begin
        rdata[0]            = en;
        rdata[8 +: CH_NUM]  = oe;
        rdata[23:16]        = psc;
      end else if (off == OFF_PERIOD) begin
        rdata[CNT_WIDTH-1:0] = period_sh;
      end else if (off == OFF_STATUS) begin
        rdata[0] = done;
`ifdef PWM_LBUS_IRQ_EN
        rdata[1] = irq_en;
`endif
      end else begin
        for (int i = 0; i < CH_NUM; i++) begin
          if (off == 8'(2 + i)) begin
            rdata[CNT_WIDTH-1:0] = duty_sh[i];
          end
        end
      end
    end
  end

  // Write-data bits that no register holds.
  logic unused_wdata;
  assign unused_wdata = ^lb_wdata;

endmodule

// File: doc/pwm_lbus.md
# pwm_lbus

Multi-channel PWM generator on the XT_LB low-speed bus. It occupies one slave slot next to the LED, LEDSD and AF_GPIO slaves. Its `pwm_out` lines feed AF_GPIO function-output slots. Period and duty values are written through shadow registers and take effect only at a period boundary, so the outputs never glitch.

## Interface
- `CH_NUM`, 4: number of PWM channels, 1..8.
- `CNT_WIDTH`, 16: counter, period and duty width, 2..24.
- `BASE_ADDR`, 8'd40: word address of register 0 on XT_LB.
- `clk` input 1: peripheral clock, all logic on its rising edge.
- `rstn` input 1: reset, asynchronous and active-low.
- `lb_sel` input 1: slave selected this cycle.
- `lb_we` input 1: 1 = write, 0 = read.
- `lb_addr` input 8: word address.
- `lb_wdata` input 32: write data.
- `rdata` output 32: read data, combinational, 0 when not selected or address unmapped.
- `pwm_out` output CH_NUM: registered PWM outputs.
- `irq` output 1: period-done interrupt, level. Present only with `PWM_LBUS_IRQ_EN`.

## Operation
- Register map (word offsets from `BASE_ADDR`):
  - +0 CTRL: bit0 `en`; bits[8+CH_NUM-1:8] per-channel `oe`; bits[23:16] `psc`.
  - +1 PERIOD: `period_sh`.
  - +2..+1+CH_NUM DUTY[i]: `duty_sh[i]`.
  - +2+CH_NUM STATUS: bit0 `done`, write-1-to-clear; bit1 `irq_en`.
  - Unused bits read 0 and ignore writes.
- Writes take effect on the rising edge where `lb_sel & lb_we` is high. Reads return shadow values.
- Prescaler `pcnt` (8 bit):
  - While `en`, it counts 0..`psc`.
  - `tick` = (`pcnt`==`psc`), and `pcnt` returns to 0 on the same edge.
  - `psc`=0 gives a tick every cycle.
- Counter `cnt`:
  - On `tick`, if `cnt`==`period_act` then `cnt`<=0 and `wrap`=1; otherwise `cnt`<=`cnt`+1.
  - The compare is modulo-free; `cnt` never exceeds `period_act`.
- Shadow load:
  - On `wrap`, `period_act`<=`period_sh` and `duty_act[i]`<=`duty_sh[i]`.
  - While `en`=0, the active registers copy the shadows every cycle.
- Output: `pwm_out[i]` <= `en & oe[i] & (cnt < duty_act[i])`, using the `cnt` value before the update.
  - `duty`=0 gives constant low.
  - `duty` > `period` gives constant high.
- Disable (`en` written 0): `pcnt` and `cnt` clear to 0 on that edge. All `pwm_out` are low from the next edge.
- Re-enable: counting restarts from `cnt`=0 with fresh active values.
- `period`=0: every tick is a wrap. The output is constant high if `duty`>0, else low.
- `done` is set on every `wrap`.
  - If a wrap and a W1C clear of `done` occur on the same edge, the set wins.

## Timing
- Reset values: all registers 0, `cnt`=0, `pcnt`=0, `pwm_out`=0, `irq`=0, `rdata`=0.
- Enable write at edge E:
  - `cnt`=0 after E; the first `pwm_out` is valid after E+1.
  - Output period = (`period`+1)·(`psc`+1) clocks.
  - High time = min(`duty`, `period`+1)·(`psc`+1) clocks.
- Duty/period write mid-period: the current period completes with the old values. The new values apply from the first output after the wrap.
- `rdata` reflects a write on the cycle after the write edge.
- `irq` (config on) = `done & irq_en`, registered. It rises one cycle after the wrap edge.

## Configuration
- `PWM_LBUS_IRQ_EN` defined:
  - STATUS.bit1 `irq_en` is implemented.
  - The `irq` port exists and is driven as above.
- `PWM_LBUS_IRQ_EN` undefined:
  - The `irq` port is absent.
  - STATUS.bit1 reads 0.
  - The `done` flag and its W1C behaviour remain.

## Test plan
- Reset: assert `rstn`=0 mid-run with `en`=1 → `pwm_out`=0 and all registers read 0 immediately; after release, CTRL reads 0.
- Basic PWM, ch0: `psc`=0, `period`=9, `duty0`=3, `oe`=1, `en`=1 → `pwm_out[0]` is high 3 clocks, low 7 clocks, repeating every 10 clocks.
- Prescaler: `psc`=3, `period`=4, `duty0`=2 → high 8 clocks, low 12 clocks, period 20 clocks.
- Shadow update: while running `period`=9, `duty0`=3, write `duty0`=7 at `cnt`=5 → current period stays 3 high; next period is 7 high, starting exactly at the wrap.
- Boundaries:
  - `duty0`=0 → constant low.
  - `duty0`=10 with `period`=9 → constant high.
  - `period`=0, `duty0`=1 → constant high.
  - `oe0`=0 → low regardless of duty.
- Done/IRQ (`PWM_LBUS_IRQ_EN`): `irq_en`=1, `period`=4 → `irq` rises one cycle after each wrap. Write STATUS=1 on the same edge as a wrap → `done` stays 1. Write STATUS=1 on a non-wrap edge → `done`=0 and `irq`=0 on the next cycle.
